// File: rtl/pipe_credit_buffer_if.sv
// pipe_credit_buffer_if: credit-issue, pipe-result and output-stream bundle.
// master = upstream issuer/pipe plus downstream sink; slave = the buffer.
interface pipe_credit_buffer_if #(
    parameter int DW = 16
);
    logic          issue_ok;
    logic          issue;
    logic          pipe_vld;
    logic [DW-1:0] pipe_data;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_rdy;

    modport master (
        input  issue_ok, out_vld, out_data,
        output issue, pipe_vld, pipe_data, out_rdy
    );

    modport slave (
        output issue_ok, out_vld, out_data,
        input  issue, pipe_vld, pipe_data, out_rdy
    );
endinterface

// File: rtl/pipe_credit_buffer.sv
// pipe_credit_buffer: credit-based output FIFO behind a fixed-latency pipe.
// Optional macro PCB_BYPASS_EN: empty buffer forwards pipe results same cycle.
module pipe_credit_buffer #(
    parameter int DW    = 16,
    parameter int LAT   = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    pipe_credit_buffer_if.slave        bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [1:0]                 err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < LAT + 1) begin : g_lat_chk
        $error("pipe_credit_buffer: DEPTH must be >= LAT+1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_pow2_chk
        $error("pipe_credit_buffer: DEPTH must be a power of two >= 2");
    end

    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] infl_q, infl_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [1:0]    err_q, err_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic [CW:0]   used;
    logic          empty, full, infl_z;
    logic          acc, drain, push, pop;
`ifdef PCB_BYPASS_EN
    logic          byp;
`endif

    // Credit accounting, push/pop decisions and output mux
    always_comb begin
        used         = {1'b0, occ_q} + {1'b0, infl_q};
        bus.issue_ok = used < (CW+1)'(DEPTH);
        empty        = (occ_q == '0);
        full         = (occ_q == CW'(DEPTH));
        infl_z       = (infl_q == '0);
        acc          = bus.issue & bus.issue_ok;
        drain        = bus.pipe_vld & ~infl_z;
`ifdef PCB_BYPASS_EN
        // Empty buffer: result goes straight out; skip the write if taken
        byp          = bus.pipe_vld & empty;
        bus.out_vld  = ~empty | byp;
        bus.out_data = byp ? bus.pipe_data : mem_q[rd_q];
        push         = bus.pipe_vld & (~infl_z | ~full)
                       & ~(byp & bus.out_rdy);
`else
        bus.out_vld  = ~empty;
        bus.out_data = mem_q[rd_q];
        push         = bus.pipe_vld & (~infl_z | ~full);
`endif
        pop    = bus.out_vld & bus.out_rdy & ~empty;
        infl_d = infl_q + CW'(acc) - CW'(drain);
        occ_d  = occ_q + CW'(push) - CW'(pop);
        wr_d   = wr_q + AW'(push);
        rd_d   = rd_q + AW'(pop);
        err_d  = err_q | {bus.pipe_vld & infl_z,
                          bus.issue & ~bus.issue_ok};
    end

    // Counters, pointers and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= '0;
            infl_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            err_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            infl_q <= infl_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            err_q  <= err_d;
        end
    end

    // Storage; cleared on reset so idle out_data reads as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_q] <= bus.pipe_data;
        end
    end

    assign count = occ_q;
    assign err   = err_q;
endmodule

// File: tb/tb_pipe_credit_buffer.sv
// tb_pipe_credit_buffer: scoreboard bench with a behavioural LAT-stage pipe.
// Expected results are queued when the pipe presents them; a monitor pops.
module tb_pipe_credit_buffer;
    localparam int DW    = 16;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] count;
    logic [1:0]    err;

    always #5 clk = ~clk;

    pipe_credit_buffer_if #(.DW(DW)) bus ();

    pipe_credit_buffer #(
        .DW(DW), .LAT(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .count (count),
        .err   (err)
    );

    int passed = 0;
    int total  = 0;
    int pops   = 0;

    logic [DW-1:0] exp_q [$];
    logic          pv [LAT];
    logic [DW-1:0] pd [LAT];
    logic [DW-1:0] tag;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    // Downstream monitor: every accepted beat must match the queue head
    always @(negedge clk) begin
        if (!rst && bus.out_vld && bus.out_rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                chk("out_data", 32'(bus.out_data),
                    32'(exp_q.pop_front()));
                pops++;
            end
        end
    end

    task automatic present(input bit iss, input bit rdy);
        bus.issue     = iss;
        bus.out_rdy   = rdy;
        bus.pipe_vld  = pv[LAT-1];
        bus.pipe_data = pd[LAT-1];
        if (pv[LAT-1]) exp_q.push_back(pd[LAT-1]);
    endtask

    task automatic advance(input bit acc);
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = acc;
        pd[0] = tag;
        if (acc) tag++;
        chk("count_vs_model", 32'(count), 32'(exp_q.size()));
    endtask

    task automatic step(input bit iss, input bit rdy, output bit acc);
        present(iss, rdy);
        #1;
        acc = iss & bus.issue_ok;
        advance(acc);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.issue     = 1'b0;
        bus.pipe_vld  = 1'b0;
        bus.pipe_data = '0;
        bus.out_rdy   = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_ok", 32'(bus.issue_ok), 32'd1);
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        int n;
        int p0;

        tag = '0;
        do_reset();

        // Streaming with no backpressure
        for (int k = 0; k < 20 + LAT + 2; k++) begin
            step(k < 20, 1'b1, acc);
            if (k < 20) chk("t2_issue_ok", 32'(acc), 32'd1);
            chk("t2_count_le1", 32'(count <= 1), 32'd1);
        end
        chk("t2_pops", 32'(pops), 32'd20);
        chk("t2_err", 32'(err), 32'd0);

        // Backpressure: exactly DEPTH credits available
        n = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, acc);
            n += int'(acc);
        end
        for (int k = 0; k < LAT + 1; k++) step(1'b0, 1'b0, acc);
        chk("t3_accepted", 32'(n), 32'(DEPTH));
        chk("t3_count_full", 32'(count), 32'(DEPTH));
        chk("t3_issue_ok_low", 32'(bus.issue_ok), 32'd0);

        // Issue without credit sets err[0] and is not taken
        step(1'b1, 1'b0, acc);
        chk("t5_issue_ignored", 32'(acc), 32'd0);
        chk("t5_err0", 32'(err), 32'd1);

        // Credit returns one cycle after the first pop
        present(1'b0, 1'b1);
        #1;
        chk("t3_ok_during_pop", 32'(bus.issue_ok), 32'd0);
        advance(1'b0);
        chk("t3_ok_after_pop", 32'(bus.issue_ok), 32'd1);
        for (int k = 0; k < DEPTH + 2; k++) step(1'b0, 1'b1, acc);
        chk("t3_pops", 32'(pops), 32'(20 + DEPTH));
        chk("t3_drained", 32'(bus.out_vld), 32'd0);

        // Random backpressure, 100 ops, pointers wrap many times
        n  = 0;
        p0 = pops;
        for (int k = 0; k < 2000 && n < 100; k++) begin
            step(1'b1, 1'($urandom_range(0, 1)), acc);
            n += int'(acc);
            chk("t4_count_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
        end
        for (int k = 0; k < LAT + DEPTH + 4; k++) step(1'b0, 1'b1, acc);
        chk("t4_issued", 32'(n), 32'd100);
        chk("t4_pops", 32'(pops - p0), 32'd100);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Empty buffer receives a result: bypass vs registered path
        tag = 16'h00A5;
        step(1'b1, 1'b1, acc);
        for (int k = 0; k < LAT - 1; k++) step(1'b0, 1'b1, acc);
        present(1'b0, 1'b1);
        #1;
`ifdef PCB_BYPASS_EN
        chk("t6_byp_vld", 32'(bus.out_vld), 32'd1);
        chk("t6_byp_data", 32'(bus.out_data), 32'h00A5);
        advance(1'b0);
        chk("t6_byp_count", 32'(count), 32'd0);
`else
        chk("t6_reg_vld_low", 32'(bus.out_vld), 32'd0);
        advance(1'b0);
        chk("t6_reg_vld", 32'(bus.out_vld), 32'd1);
        chk("t6_reg_data", 32'(bus.out_data), 32'h00A5);
`endif
        step(1'b0, 1'b1, acc);
        chk("t6_empty", 32'(count), 32'd0);

        // Result with nothing in flight sets err[1], data still delivered
        present(1'b0, 1'b1);
        bus.pipe_vld  = 1'b1;
        bus.pipe_data = 16'h1234;
        exp_q.push_back(16'h1234);
        advance(1'b0);
        chk("t5_err1", 32'(err), 32'd3);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, acc);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_err_sticky", 32'(err), 32'd3);

        // Reset mid-operation with ops in flight and data held
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, acc);
        chk("mid_count_nz", 32'(count != 0), 32'd1);
        do_reset();
        for (int k = 0; k < LAT + 2; k++) step(1'b0, 1'b1, acc);
        chk("post_rst_err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
